// File: rtl/button_event_queue_if.sv
// Processor-side and debounce-side signal bundle for button_event_queue.
// The slave modport is the queue; the master modport drives buttons and pops.
interface button_event_queue_if #(
  parameter int unsigned NUM_BUTTONS = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned CNT_W       = 3
);
  logic [NUM_BUTTONS-1:0] debounce_in;
  logic                   rd_en;
  logic                   clear_overflow;
  logic                   event_valid;
  logic [ID_W-1:0]        event_id;
  logic [CNT_W-1:0]       event_count;
  logic                   accept;
  logic                   overflow;

  modport master (
    output debounce_in, rd_en, clear_overflow,
    input  event_valid, event_id, event_count, accept, overflow
  );

  modport slave (
    input  debounce_in, rd_en, clear_overflow,
    output event_valid, event_id, event_count, accept, overflow
  );
endinterface

// File: rtl/button_event_queue.sv
// Turns debounced button levels into one queued press event each, arbitrates
// simultaneous presses lowest-index first, and buffers them in a small FWFT FIFO.
module button_event_queue #(
  parameter int unsigned NUM_BUTTONS = 4,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned CNT_W       = 3
) (
  input  logic                 clock,
  input  logic                 resetn,
  button_event_queue_if.slave  bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NUM_BUTTONS-1:0] prev;
  logic [NUM_BUTTONS-1:0] pending;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   overflow_q;
  logic                   valid_q;
  logic [ID_W-1:0]        id_q;
  logic                   accept_q;
  logic [ID_W-1:0]        storage [DEPTH];

  logic [NUM_BUTTONS-1:0] rise;
  logic [NUM_BUTTONS-1:0] cand;
  logic [NUM_BUTTONS-1:0] win_onehot;
  logic [NUM_BUTTONS-1:0] pending_next;
  logic [ID_W-1:0]        win_idx;
  logic                   found;
  logic                   not_full;
  logic                   can_write;
  logic                   push;
  logic                   pop;
  logic [CNT_W-1:0]       count_next;
  logic [PTR_W-1:0]       rd_ptr_next;
  logic [PTR_W-1:0]       wr_ptr_next;
  logic [ID_W-1:0]        head_next;
  logic                   accept_next;
  logic                   overflow_next;

  // Edge detect, arbitration and next-state for pointers, count and flags.
  always_comb begin
    rise          = bus.debounce_in & ~prev;
    cand          = pending | rise;
    win_idx       = '0;
    win_onehot    = '0;
    found         = 1'b0;
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      if (cand[i] && !found) begin
        found         = 1'b1;
        win_idx       = ID_W'(i);
        win_onehot[i] = 1'b1;
      end
    end

    not_full      = (count < CNT_W'(DEPTH));
    can_write     = not_full || bus.rd_en;
    push          = can_write && found;
    pop           = bus.rd_en && (count != '0);
    pending_next  = cand & ~(push ? win_onehot : '0);

    count_next    = count;
    if (push && !pop) count_next = count + CNT_W'(1);
    if (pop && !push) count_next = count - CNT_W'(1);

    rd_ptr_next   = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
    wr_ptr_next   = push ? wr_ptr + PTR_W'(1) : wr_ptr;

    // The new head may be the entry being written this very cycle.
    if (count_next == '0)
      head_next = '0;
    else if (push && (wr_ptr == rd_ptr_next))
      head_next = win_idx;
    else
      head_next = storage[rd_ptr_next];

    accept_next   = (count_next < CNT_W'(DEPTH)) && (pending_next == '0);

    // A set in the same cycle as a clear wins.
    overflow_next = overflow_q;
    if (bus.clear_overflow)      overflow_next = 1'b0;
    if ((rise & pending) != '0)  overflow_next = 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      prev       <= '0;
      pending    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      id_q       <= '0;
      accept_q   <= 1'b1;
    end else begin
      prev       <= bus.debounce_in;
      pending    <= pending_next;
      wr_ptr     <= wr_ptr_next;
      rd_ptr     <= rd_ptr_next;
      count      <= count_next;
      overflow_q <= overflow_next;
      valid_q    <= (count_next != '0);
      id_q       <= head_next;
      accept_q   <= accept_next;
    end
  end

  // Event storage carries no reset; validity is tracked by count.
  always_ff @(posedge clock) begin
    if (push) storage[wr_ptr] <= win_idx;
  end

  assign bus.event_valid = valid_q;
  assign bus.event_id    = id_q;
  assign bus.event_count = count;
  assign bus.accept      = accept_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_button_event_queue.sv
// Randomized and directed bench for button_event_queue against a queue-based
// reference model of press events.
module tb_button_event_queue;

  localparam int NB    = 4;
  localparam int DEPTH = 4;

  logic clock;
  logic resetn;

  button_event_queue_if #(.NUM_BUTTONS(4), .ID_W(2), .CNT_W(3)) bus ();

  button_event_queue #(.NUM_BUTTONS(4), .DEPTH(4), .ID_W(2), .CNT_W(3)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a queue of pressed button IDs plus press bookkeeping.
  int unsigned    mq[$];
  logic [NB-1:0]  m_prev;
  logic [NB-1:0]  m_pend;
  logic           m_ovf;
  logic           e_valid;
  logic [1:0]     e_id;
  logic [2:0]     e_cnt;
  logic           e_acc;

  function void model_expect();
    e_valid = (mq.size() != 0);
    e_id    = (mq.size() != 0) ? 2'(mq[0]) : 2'd0;
    e_cnt   = 3'(mq.size());
    e_acc   = (mq.size() < DEPTH) && (m_pend == '0);
  endfunction

  function void model_reset();
    mq.delete();
    m_prev = '0;
    m_pend = '0;
    m_ovf  = 1'b0;
    model_expect();
  endfunction

  function void model_step(input logic [NB-1:0] din, input logic rd, input logic clr);
    logic [NB-1:0] rise;
    logic [NB-1:0] cand;
    bit            room;
    bit            take;
    int            win;
    rise = din & ~m_prev;
    cand = m_pend | rise;
    room = (mq.size() < DEPTH) || rd;
    take = rd && (mq.size() > 0);
    win  = -1;
    if (room) begin
      for (int i = NB - 1; i >= 0; i--) if (cand[i]) win = i;
    end
    if (win >= 0) cand[win] = 1'b0;
    if ((rise & m_pend) != '0) m_ovf = 1'b1;
    else if (clr)              m_ovf = 1'b0;
    m_pend = cand;
    m_prev = din;
    if (take) void'(mq.pop_front());
    if (win >= 0) mq.push_back(win);
    model_expect();
  endfunction

  task automatic cycle();
    @(posedge clock);
    model_step(bus.debounce_in, bus.rd_en, bus.clear_overflow);
    #1;
  endtask

  task automatic do_reset();
    resetn             = 1'b0;
    bus.debounce_in    = '0;
    bus.rd_en          = 1'b0;
    bus.clear_overflow = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({bus.event_valid, bus.event_id, bus.event_count, bus.accept, bus.overflow} !== {1'b0, 2'd0, 3'd0, 1'b1, 1'b0})
      $display("FAIL reset_state got v=%b id=%0d cnt=%0d acc=%b ovf=%b want 0/0/0/1/0",
               bus.event_valid, bus.event_id, bus.event_count, bus.accept, bus.overflow);
    else n_pass++;
    resetn = 1'b1;
  endtask

  task automatic test_single_press();
    do_reset();
    bus.debounce_in = 4'b0100;
    cycle();
    n_checks++;
    if ({bus.event_valid, bus.event_id, bus.event_count} !== {1'b1, 2'd2, 3'd1})
      $display("FAIL single_first got v=%b id=%0d cnt=%0d want 1/2/1", bus.event_valid, bus.event_id, bus.event_count);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      cycle();
      n_checks++;
      if (bus.event_count !== 3'd1)
        $display("FAIL single_held got cnt=%0d want 1", bus.event_count);
      else n_pass++;
    end
    bus.debounce_in = '0;
    bus.rd_en       = 1'b1;
    cycle();
    bus.rd_en = 1'b0;
    n_checks++;
    if ({bus.event_valid, bus.event_count} !== {1'b0, 3'd0})
      $display("FAIL single_pop got v=%b cnt=%0d want 0/0", bus.event_valid, bus.event_count);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    int order [3] = '{0, 1, 3};
    logic [2:0] want_cnt [3] = '{3'd1, 3'd2, 3'd3};
    logic       want_acc [3] = '{1'b0, 1'b0, 1'b1};
    do_reset();
    bus.debounce_in = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_checks++;
      if ({bus.event_count, bus.accept, bus.event_id} !== {want_cnt[k], want_acc[k], 2'd0})
        $display("FAIL simul_fill%0d got cnt=%0d acc=%b id=%0d want %0d/%b/0",
                 k, bus.event_count, bus.accept, bus.event_id, want_cnt[k], want_acc[k]);
      else n_pass++;
    end
    bus.rd_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({bus.event_valid, bus.event_id} !== {1'b1, 2'(order[k])})
        $display("FAIL simul_drain%0d got v=%b id=%0d want 1/%0d", k, bus.event_valid, bus.event_id, order[k]);
      else n_pass++;
      cycle();
    end
    bus.rd_en = 1'b0;
    n_checks++;
    if (bus.event_valid !== 1'b0)
      $display("FAIL simul_empty got v=%b want 0", bus.event_valid);
    else n_pass++;
  endtask

  task automatic test_full_pending();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus.debounce_in = 4'b0010; cycle();
      bus.debounce_in = 4'b0000; cycle();
    end
    n_checks++;
    if ({bus.event_count, bus.accept} !== {3'd4, 1'b0})
      $display("FAIL full_count got cnt=%0d acc=%b want 4/0", bus.event_count, bus.accept);
    else n_pass++;
    bus.debounce_in = 4'b0010; cycle();
    bus.debounce_in = 4'b0000;
    bus.rd_en       = 1'b1;
    cycle();
    bus.rd_en = 1'b0;
    n_checks++;
    if ({bus.event_count, bus.event_id, bus.accept} !== {3'd4, e_id, e_acc} || e_cnt !== 3'd4)
      $display("FAIL full_refill got cnt=%0d id=%0d acc=%b want 4/%0d/%b",
               bus.event_count, bus.event_id, bus.accept, e_id, e_acc);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int ids[$];
    int n2;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus.debounce_in = 4'b0001; cycle();
      bus.debounce_in = 4'b0000; cycle();
    end
    bus.debounce_in = 4'b0100; cycle();
    bus.debounce_in = 4'b0000; cycle();
    bus.debounce_in = 4'b0100; cycle();
    n_checks++;
    if (bus.overflow !== 1'b1)
      $display("FAIL ovf_set got %b want 1", bus.overflow);
    else n_pass++;
    bus.debounce_in    = 4'b0000;
    bus.clear_overflow = 1'b1;
    cycle();
    bus.clear_overflow = 1'b0;
    n_checks++;
    if (bus.overflow !== 1'b0)
      $display("FAIL ovf_clear got %b want 0", bus.overflow);
    else n_pass++;
    bus.rd_en = 1'b1;
    for (int k = 0; k < 10 && bus.event_valid === 1'b1; k++) begin
      ids.push_back(int'(bus.event_id));
      cycle();
    end
    bus.rd_en = 1'b0;
    n2 = 0;
    foreach (ids[i]) if (ids[i] == 2) n2++;
    n_checks++;
    if (ids.size() != 5 || n2 != 1 || ids[4] != 2)
      $display("FAIL ovf_drain got %0d events with %0d of id2 want 5 events, one id2 last", ids.size(), n2);
    else n_pass++;
  endtask

  task automatic test_push_pop_wrap();
    do_reset();
    bus.debounce_in = 4'b1000; cycle();
    bus.debounce_in = 4'b0000; cycle();
    bus.debounce_in = 4'b0010; cycle();
    bus.debounce_in = 4'b0000; cycle();
    bus.rd_en = 1'b1;
    for (int j = 0; j < 10; j++) begin
      bus.debounce_in = 4'(1 << (j % 4));
      cycle();
      n_checks++;
      if ({bus.event_count, bus.event_id} !== {3'd2, e_id})
        $display("FAIL wrap%0d got cnt=%0d id=%0d want 2/%0d", j, bus.event_count, bus.event_id, e_id);
      else n_pass++;
    end
    bus.rd_en       = 1'b0;
    bus.debounce_in = 4'b0000;
    cycle();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.debounce_in    = bus.debounce_in ^ 4'($urandom & $urandom);
      bus.rd_en          = ($urandom_range(0, 2) == 0);
      bus.clear_overflow = ($urandom_range(0, 9) == 0);
      cycle();
      n_checks++;
      if ({bus.event_valid, bus.event_id, bus.event_count, bus.accept, bus.overflow} !==
          {e_valid, e_id, e_cnt, e_acc, m_ovf}) begin
        errs++;
        if (errs <= 5)
          $display("FAIL random_c%0d got v=%b id=%0d cnt=%0d acc=%b ovf=%b want %b/%0d/%0d/%b/%b",
                   c, bus.event_valid, bus.event_id, bus.event_count, bus.accept, bus.overflow,
                   e_valid, e_id, e_cnt, e_acc, m_ovf);
      end else n_pass++;
    end
    bus.rd_en          = 1'b0;
    bus.clear_overflow = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.debounce_in = 4'b1111;
    for (int k = 0; k < 3; k++) cycle();
    n_checks++;
    if ({bus.event_count, bus.accept} !== {3'd3, 1'b0})
      $display("FAIL mid_setup got cnt=%0d acc=%b want 3/0", bus.event_count, bus.accept);
    else n_pass++;
    resetn = 1'b0;
    #2;
    n_checks++;
    if ({bus.event_valid, bus.event_count, bus.accept, bus.overflow} !== {1'b0, 3'd0, 1'b1, 1'b0})
      $display("FAIL mid_reset got v=%b cnt=%0d acc=%b ovf=%b want 0/0/1/0",
               bus.event_valid, bus.event_count, bus.accept, bus.overflow);
    else n_pass++;
    resetn = 1'b1;
    model_reset();
    cycle();
    n_checks++;
    if ({bus.event_valid, bus.event_id, bus.event_count, bus.accept} !== {e_valid, e_id, e_cnt, e_acc})
      $display("FAIL held_after_reset got v=%b id=%0d cnt=%0d acc=%b want %b/%0d/%0d/%b",
               bus.event_valid, bus.event_id, bus.event_count, bus.accept, e_valid, e_id, e_cnt, e_acc);
    else n_pass++;
  endtask

  initial begin
    resetn             = 1'b0;
    bus.debounce_in    = '0;
    bus.rd_en          = 1'b0;
    bus.clear_overflow = 1'b0;
    test_reset();
    test_single_press();
    test_simultaneous();
    test_full_pending();
    test_overflow();
    test_push_pop_wrap();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
